// File: rtl/game_pkg.sv
// Shared types and constants for the number-guessing round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    CHECK,
    WIN,
    LOSE,
    NEXT,
    DONE
  } state_e;

  localparam int unsigned HINT_W = 2;
  localparam logic [HINT_W-1:0] HINT_NONE = 2'b00;
  localparam logic [HINT_W-1:0] HINT_LOW  = 2'b01;
  localparam logic [HINT_W-1:0] HINT_HIGH = 2'b10;

  // Fibonacci taps 8,6,5,4 (x^8 + x^6 + x^5 + x^4 + 1), maximal length
  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round countdown: tick divider running only while enabled, plus 7-bit timer.
module round_timer #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned ROUND_TIME = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       run,
  output logic       tick_c,
  output logic       zero_c,
  output logic [6:0] timer
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] div;

  assign tick_c = run && (div == DIV_W'(TICK_DIV - 1));
  assign zero_c = (timer == 7'd0);

  // Divider is held at zero outside the run window so every entry starts a fresh tick period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (!run || tick_c) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Countdown: reload on load, decrement once per tick, never below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 7'd0;
    end else if (load) begin
      timer <= 7'(ROUND_TIME);
    end else if (tick_c && !zero_c) begin
      timer <= timer - 7'd1;
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer for one game: secret pick, guess check, per-round timer, scoring.
// Optional magnitude hint output enabled by defining ROUND_CTRL_HINT_EN.
module round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ROUND_TIME  = 30,
  parameter int unsigned MAX_GUESSES = 5,
  parameter int unsigned NUM_ROUNDS  = 3,
  parameter int unsigned DIGIT_W     = 4
) (
  input  logic               clk,
  input  logic               restart,
  input  logic               start,
  input  logic               confirmButton,
  input  logic [DIGIT_W-1:0] guess,
  output logic [1:0]         round,
  output logic [6:0]         timer,
  output logic [2:0]         incorrect_guesses,
  output logic               round_win,
  output logic               round_lose,
  output logic               game_over,
  output logic [1:0]         score,
  output logic [HINT_W-1:0]  hint
);

  state_e              state;
  logic [LFSR_W-1:0]   lfsr;
  logic [DIGIT_W-1:0]  secret;
  logic [DIGIT_W-1:0]  guess_q;
  logic                conf_q;
  logic                start_q;
  logic                conf_pulse_c;
  logic                start_rise_c;
  logic                tick_c;
  logic                zero_c;
  logic                timeout_c;
  logic                load_c;
  logic                run_c;
  logic [2:0]          inc_next_c;

  assign conf_pulse_c = confirmButton & ~conf_q;
  assign start_rise_c = start & ~start_q;
  assign load_c       = (state == LOAD);
  assign run_c        = (state == PLAY);
  // zero_c only matters for a degenerate zero-length round
  assign timeout_c    = (tick_c && (timer == 7'd1)) || zero_c;
  assign inc_next_c   = incorrect_guesses + 3'd1;

  round_timer #(
    .TICK_DIV  (TICK_DIV),
    .ROUND_TIME(ROUND_TIME)
  ) u_timer (
    .clk   (clk),
    .rst_n (restart),
    .load  (load_c),
    .run   (run_c),
    .tick_c(tick_c),
    .zero_c(zero_c),
    .timer (timer)
  );

  // Free-running secret source plus button/start edge history
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      lfsr    <= LFSR_W'(1);
      conf_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      lfsr    <= lfsr_next(lfsr);
      conf_q  <= confirmButton;
      start_q <= start;
    end
  end

  // Round sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state             <= IDLE;
      round             <= 2'd0;
      incorrect_guesses <= 3'd0;
      round_win         <= 1'b0;
      round_lose        <= 1'b0;
      game_over         <= 1'b0;
      score             <= 2'd0;
      secret            <= '0;
      guess_q           <= '0;
`ifdef ROUND_CTRL_HINT_EN
      hint              <= HINT_NONE;
`endif
    end else begin
      round_win  <= 1'b0;
      round_lose <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            round <= 2'd1;
            score <= 2'd0;
          end
        end
        LOAD: begin
          secret            <= lfsr[DIGIT_W-1:0];
          incorrect_guesses <= 3'd0;
`ifdef ROUND_CTRL_HINT_EN
          hint              <= HINT_NONE;
`endif
          state             <= PLAY;
        end
        PLAY: begin
          if (timeout_c) begin
            state      <= LOSE;
            round_lose <= 1'b1;
          end else if (conf_pulse_c) begin
            guess_q <= guess;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (guess_q == secret) begin
            state     <= WIN;
            round_win <= 1'b1;
            if (score != 2'd3) begin
              score <= score + 2'd1;
            end
          end else begin
            incorrect_guesses <= inc_next_c;
`ifdef ROUND_CTRL_HINT_EN
            hint <= (guess_q < secret) ? HINT_LOW : HINT_HIGH;
`endif
            if (inc_next_c == 3'(MAX_GUESSES)) begin
              state      <= LOSE;
              round_lose <= 1'b1;
            end else begin
              state <= PLAY;
            end
          end
        end
        WIN, LOSE: begin
          state <= NEXT;
        end
        NEXT: begin
          if (round == 2'(NUM_ROUNDS)) begin
            state     <= DONE;
            game_over <= 1'b1;
          end else begin
            round <= round + 2'd1;
            state <= LOAD;
          end
        end
        DONE: begin
          if (start_rise_c) begin
            state     <= LOAD;
            round     <= 2'd1;
            score     <= 2'd0;
            game_over <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ROUND_CTRL_HINT_EN
  assign hint = HINT_NONE;
`endif

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboarded bench for round_ctrl: directed games with hand-derived expectations.
module tb_round_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       restart = 1'b0;
  logic       start = 1'b0;
  logic       confirmButton = 1'b0;
  logic [3:0] guess = 4'd0;
  logic [1:0] round;
  logic [6:0] timer;
  logic [2:0] incorrect_guesses;
  logic       round_win;
  logic       round_lose;
  logic       game_over;
  logic [1:0] score;
  logic [1:0] hint_out;

  typedef struct packed {
    logic       win;
    logic [1:0] rnd;
    logic [1:0] scr;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] s;
  logic [3:0] g;

  always #5 clk = ~clk;

  round_ctrl #(
    .TICK_DIV   (4),
    .ROUND_TIME (30),
    .MAX_GUESSES(5),
    .NUM_ROUNDS (3),
    .DIGIT_W    (4)
  ) dut (
    .clk              (clk),
    .restart          (restart),
    .start            (start),
    .confirmButton    (confirmButton),
    .guess            (guess),
    .round            (round),
    .timer            (timer),
    .incorrect_guesses(incorrect_guesses),
    .round_win        (round_win),
    .round_lose       (round_lose),
    .game_over        (game_over),
    .score            (score),
    .hint             (hint_out)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First held edge produces the pulse; the button is released after 'hold' edges
  task automatic press(input logic [3:0] gv, input int hold);
    guess = gv;
    confirmButton = 1'b1;
    repeat (hold) step();
    confirmButton = 1'b0;
  endtask

  function automatic logic [3:0] wrong_guess(input logic [3:0] sv, input int k);
    if (k % 2 == 0) return (sv == 4'd0) ? 4'd15 : 4'd0;
    else return (sv == 4'd15) ? 4'd0 : 4'd15;
  endfunction

  function automatic logic [1:0] exp_hint(input logic [3:0] gv, input logic [3:0] sv);
`ifdef ROUND_CTRL_HINT_EN
    return (gv < sv) ? HINT_LOW : HINT_HIGH;
`else
    return HINT_NONE;
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_round"}, round, 0);
    check({tag, "_timer"}, timer, 0);
    check({tag, "_incorrect"}, incorrect_guesses, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_hint"}, hint_out, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_round_win"}, round_win, 0);
    check({tag, "_round_lose"}, round_lose, 0);
  endtask

  // Monitor: every result pulse must match the next queued expectation
  always @(negedge clk) begin
    if (round_win || round_lose) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: win=%0d lose=%0d round=%0d with nothing expected",
                 round_win, round_lose, round);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_win", round_win, mon_e.win);
        check("pulse_lose", round_lose, !mon_e.win);
        check("pulse_round", round, mon_e.rnd);
        check("pulse_score", score, mon_e.scr);
      end
    end
  end

  initial begin
    repeat (3) step();
    check_reset_values("reset");
    restart = 1'b1;

    // Game 1: start, LOAD, timer countdown
    start = 1'b1;
    step();
    check("start_round", round, 1);
    step();
    start = 1'b0;
    check("load_timer", timer, 30);
    check("load_incorrect", incorrect_guesses, 0);
    repeat (8) step();
    check("timer_after_8", timer, 28);

    // Round 1: correct guess
    s = dut.secret;
    exp_q.push_back('{1'b1, 2'd1, 2'd1});
    press(s, 1);
    repeat (4) step();
    check("r1_next_round", round, 2);
    check("r1_timer_reload", timer, 30);
    check("r1_score", score, 1);

    // Round 2: five wrong guesses, first one held for 10 cycles
    s = dut.secret;
    for (int k = 0; k < 4; k++) begin
      g = wrong_guess(s, k);
      press(g, (k == 0) ? 10 : 1);
      step();
      check("r2_incorrect", incorrect_guesses, k + 1);
      check("r2_hint", hint_out, exp_hint(g, s));
    end
    exp_q.push_back('{1'b0, 2'd2, 2'd1});
    press(wrong_guess(s, 4), 1);
    step();
    check("r2_lose_pulse", round_lose, 1);
    check("r2_incorrect_max", incorrect_guesses, 5);
    repeat (3) step();
    check("r2_next_round", round, 3);
    check("r3_timer_reload", timer, 30);
    check("r3_incorrect_clear", incorrect_guesses, 0);
    check("r3_hint_clear", hint_out, 0);

    // Round 3: timeout, with a correct confirm landing on the final tick
    s = dut.secret;
    repeat (119) step();
    check("r3_timer_last", timer, 1);
    guess = s;
    confirmButton = 1'b1;
    exp_q.push_back('{1'b0, 2'd3, 2'd1});
    step();
    confirmButton = 1'b0;
    check("r3_timer_zero", timer, 0);
    check("r3_timeout_lose", round_lose, 1);
    repeat (2) step();
    check("g1_game_over", game_over, 1);
    check("g1_score", score, 1);
    check("g1_round", round, 3);
    check("g1_confirm_ignored", incorrect_guesses, 0);
    repeat (5) step();
    check("g1_hold_game_over", game_over, 1);
    check("g1_hold_timer", timer, 0);
    check("g1_hold_round", round, 3);
    check("g1_hold_score", score, 1);

    // Game 2: restart by start edge, then win, lose, win
    start = 1'b1;
    step();
    check("g2_round", round, 1);
    check("g2_score", score, 0);
    check("g2_game_over", game_over, 0);
    step();
    start = 1'b0;
    check("g2_timer", timer, 30);

    s = dut.secret;
    exp_q.push_back('{1'b1, 2'd1, 2'd1});
    press(s, 1);
    repeat (4) step();
    check("g2_r2_round", round, 2);

    s = dut.secret;
    for (int k = 0; k < 5; k++) begin
      g = wrong_guess(s, k);
      if (k == 4) exp_q.push_back('{1'b0, 2'd2, 2'd1});
      press(g, 1);
      step();
      check("g2_hint", hint_out, exp_hint(g, s));
      check("g2_incorrect", incorrect_guesses, k + 1);
    end
    repeat (3) step();
    check("g2_r3_round", round, 3);

    s = dut.secret;
    exp_q.push_back('{1'b1, 2'd3, 2'd2});
    press(s, 1);
    repeat (3) step();
    check("g2_game_over", game_over, 1);
    check("g2_final_score", score, 2);
    check("g2_final_round", round, 3);

    // Game 3: asynchronous reset in the middle of PLAY
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    repeat (5) step();
    check("g3_round", round, 1);
    #2;
    restart = 1'b0;
    #1;
    check_reset_values("async_reset");
    step();
    restart = 1'b1;
    repeat (3) step();
    check("idle_round", round, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
